// File: rtl/seq_nonoverlap.sv
// -----------------------------------------------------------------------------
// seq_nonoverlap
//
// Serial bit-stream pattern detector with non-overlapping matching. One bit of
// x is sampled per rising clock edge. When the most recent PAT_LEN bits
// complete PATTERN (MSB received first), y is high for exactly one cycle.
// After a detection matching restarts from scratch, so no bit of a completed
// match is reused for the next one.
//
// Parameters:
//   PAT_LEN  pattern length in bits, 2..16
//   PATTERN  pattern to detect; bit PAT_LEN-1 is the first bit received
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst      synchronous active-high reset, has priority over x
//   x        serial data input
//   y        detect flag, decoded from the state register only
//   det_cnt  [7:0] saturating detection count (only when
//            SEQ_NONOVERLAP_DETCNT_EN is defined)
//
// Optional feature macro: SEQ_NONOVERLAP_DETCNT_EN
// -----------------------------------------------------------------------------
module seq_nonoverlap #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic       y
`ifdef SEQ_NONOVERLAP_DETCNT_EN
    ,
    output logic [7:0] det_cnt
`endif
);

    // State k (0 < k < PAT_LEN) means k leading pattern bits are matched.
    localparam int SW    = $clog2(PAT_LEN + 1);
    localparam int TBL_N = 2 ** (SW + 1);

    typedef enum logic [SW-1:0] {
        S_IDLE = SW'(0),
        S_DET  = SW'(PAT_LEN)
    } state_e;

    // Next-state table indexed by {state, x}. Sized to cover every encoding
    // so that unreachable states have an entry (IDLE) too.
    typedef logic [TBL_N-1:0][SW-1:0] tbl_t;

    // Bit i of the pattern in reception order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [PAT_LEN-1:0] t;
        t = PATTERN >> (PAT_LEN - 1 - i);
        return t[0];
    endfunction

    // Given k matched bits followed by bit b, return the length of the
    // longest pattern prefix that is a suffix of that (k+1)-bit string.
    // When b is the expected bit this is simply k+1; otherwise it is the
    // KMP fallback.
    function automatic int dfa_next(input int k, input logic b);
        int   best;
        int   p;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (i < j) begin
                        p = k + 1 - j + i;
                        if (p == k) begin
                            sb = b;
                        end else begin
                            sb = pat_bit(p);
                        end
                        if (sb != pat_bit(i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // DET behaves as IDLE (non-overlap rule); encodings above DET map to IDLE.
    function automatic tbl_t build_tbl();
        tbl_t t;
        int   k;
        t = '0;
        for (int st = 0; st < 2 ** SW; st++) begin
            for (int b = 0; b < 2; b++) begin
                if (st < PAT_LEN) begin
                    k = st;
                end else if (st == PAT_LEN) begin
                    k = 0;
                end else begin
                    k = -1;
                end
                if (k >= 0) begin
                    t[st * 2 + b] = SW'(dfa_next(k, b[0]));
                end
            end
        end
        return t;
    endfunction

    localparam tbl_t NEXT_TBL = build_tbl();

    state_e state_q;
    state_e state_d;

    // Next-state lookup from the elaboration-time transition table.
    always_comb begin
        state_d = S_IDLE;
        state_d = state_e'(NEXT_TBL[{state_q, x}]);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output: decoded from the state register, no path from x.
    always_comb begin
        y = (state_q == S_DET);
    end

`ifdef SEQ_NONOVERLAP_DETCNT_EN
    logic [7:0] det_cnt_q;
    logic [7:0] det_cnt_d;

    // Count entries into DET, saturating at 255; updates on the same edge
    // that raises y.
    always_comb begin
        det_cnt_d = det_cnt_q;
        if ((state_d == S_DET) && (det_cnt_q != 8'd255)) begin
            det_cnt_d = det_cnt_q + 8'd1;
        end else begin
            det_cnt_d = det_cnt_q;
        end
    end

    // Detection counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_cnt_q <= 8'd0;
        end else begin
            det_cnt_q <= det_cnt_d;
        end
    end

    // Expose the counter register directly.
    always_comb begin
        det_cnt = det_cnt_q;
    end
`endif

endmodule

// File: tb/tb_seq_nonoverlap.sv
// -----------------------------------------------------------------------------
// tb_seq_nonoverlap
//
// Drives two detectors with the same serial stream: the default 4-bit 1011
// pattern and a 5-bit 11011 pattern. A reference model (history shift
// register plus "bits since restart" counter) pushes the expected y for each
// bit into a per-DUT queue; the value is popped and compared one edge later.
// Directed tests also compare against hand-written pulse vectors.
// -----------------------------------------------------------------------------
module tb_seq_nonoverlap;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic y1;
    logic y2;
`ifdef SEQ_NONOVERLAP_DETCNT_EN
    logic [7:0] cnt1;
    logic [7:0] cnt2;
`endif

    seq_nonoverlap u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .y      (y1)
`ifdef SEQ_NONOVERLAP_DETCNT_EN
        ,
        .det_cnt(cnt1)
`endif
    );

    seq_nonoverlap #(
        .PAT_LEN(5),
        .PATTERN(5'b11011)
    ) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .y      (y2)
`ifdef SEQ_NONOVERLAP_DETCNT_EN
        ,
        .det_cnt(cnt2)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic q1[$];
    logic q2[$];

    localparam logic [3:0] P1 = 4'b1011;
    localparam logic [4:0] P2 = 5'b11011;

    logic [15:0] h1 = '0;
    logic [15:0] h2 = '0;
    int s1  = 0;
    int s2  = 0;
    int mc1 = 0;
    int mc2 = 0;

    // Drive one data bit, update the reference model, wait past the edge.
    task automatic send_bit(input logic b);
        logic e;
        rst = 1'b0;
        x   = b;
        h1  = {h1[14:0], b};
        s1++;
        if (s1 >= 4 && h1[3:0] == P1) begin
            e = 1'b1; s1 = 0; if (mc1 < 255) mc1++;
        end else begin
            e = 1'b0;
        end
        q1.push_back(e);
        h2 = {h2[14:0], b};
        s2++;
        if (s2 >= 5 && h2[4:0] == P2) begin
            e = 1'b1; s2 = 0; if (mc2 < 255) mc2++;
        end else begin
            e = 1'b0;
        end
        q2.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One reset edge with an arbitrary data bit present.
    task automatic reset_edge(input logic xb);
        rst = 1'b1;
        x   = xb;
        s1  = 0; s2 = 0; mc1 = 0; mc2 = 0;
        q1.push_back(1'b0);
        q2.push_back(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic e1, e2;
        for (int i = 0; i < 2; i++) begin
            reset_edge(i[0]);
            e1 = q1.pop_front(); e2 = q2.pop_front();
            checks += 2;
            if (y1 !== e1) begin failures++; $display("FAIL reset_y1 edge%0d got=%b exp=%b", i, y1, e1); end
            if (y2 !== e2) begin failures++; $display("FAIL reset_y2 edge%0d got=%b exp=%b", i, y2, e2); end
`ifdef SEQ_NONOVERLAP_DETCNT_EN
            checks += 2;
            if (cnt1 !== 8'd0) begin failures++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
            if (cnt2 !== 8'd0) begin failures++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
`endif
        end
    endtask

    // Run a directed stream; pulse vector holds the expected y1 (or y2) per bit.
    task automatic test_stream(input string name, input logic [15:0] bits,
                               input logic [15:0] pulse, input int n, input logic on_dut2);
        logic e1, e2, hy;
        reset_edge(1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front();
        checks++;
        if (y1 !== e1) begin failures++; $display("FAIL %s_rst got=%b exp=%b", name, y1, e1); end
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i]);
            e1 = q1.pop_front(); e2 = q2.pop_front();
            hy = on_dut2 ? y2 : y1;
            checks += 3;
            if (y1 !== e1) begin failures++; $display("FAIL %s_y1 bit%0d got=%b exp=%b", name, n - i, y1, e1); end
            if (y2 !== e2) begin failures++; $display("FAIL %s_y2 bit%0d got=%b exp=%b", name, n - i, y2, e2); end
            if (hy !== pulse[i]) begin failures++; $display("FAIL %s_vec bit%0d got=%b exp=%b", name, n - i, hy, pulse[i]); end
        end
    endtask

    task automatic test_reset_mid_match();
        logic e1, e2;
        logic [2:0] pre  = 3'b101;
        logic [4:0] post = 5'b11011;
        logic [4:0] pv   = 5'b00001;
        reset_edge(1'b0);
        void'(q1.pop_front()); void'(q2.pop_front());
        for (int i = 2; i >= 0; i--) begin
            send_bit(pre[i]);
            e1 = q1.pop_front(); e2 = q2.pop_front();
            checks++;
            if (y1 !== e1) begin failures++; $display("FAIL midrst_pre bit%0d got=%b exp=%b", 3 - i, y1, e1); end
        end
        reset_edge(1'b1);
        e1 = q1.pop_front(); e2 = q2.pop_front();
        checks++;
        if (y1 !== e1) begin failures++; $display("FAIL midrst_rst got=%b exp=%b", y1, e1); end
        for (int i = 4; i >= 0; i--) begin
            send_bit(post[i]);
            e1 = q1.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if (y1 !== e1) begin failures++; $display("FAIL midrst_y1 bit%0d got=%b exp=%b", 5 - i, y1, e1); end
            if (y2 !== e2) begin failures++; $display("FAIL midrst_y2 bit%0d got=%b exp=%b", 5 - i, y2, e2); end
            if (y1 !== pv[i]) begin failures++; $display("FAIL midrst_vec bit%0d got=%b exp=%b", 5 - i, y1, pv[i]); end
        end
    endtask

    // Repeated disjoint patterns: pulses every PAT_LEN bits, counter saturates.
    task automatic test_back_to_back();
        logic e1, e2;
        logic [4:0] p5 = 5'b11011;
        logic [3:0] p4 = 4'b1011;
        int last = -1;
        int idx  = 0;
        reset_edge(1'b0);
        void'(q1.pop_front()); void'(q2.pop_front());
        for (int r = 0; r < 20; r++) begin
            for (int i = 3; i >= 0; i--) begin
                send_bit(p4[i]);
                idx++;
                e1 = q1.pop_front(); e2 = q2.pop_front();
                checks += 2;
                if (y1 !== e1) begin failures++; $display("FAIL b2b4_y1 bit%0d got=%b exp=%b", idx, y1, e1); end
                if (y1 !== (i == 0)) begin failures++; $display("FAIL b2b4_vec bit%0d got=%b exp=%b", idx, y1, (i == 0)); end
                if (y1 === 1'b1) begin
                    if (last >= 0) begin
                        checks++;
                        if (idx - last != 4) begin failures++; $display("FAIL b2b4_gap got=%0d exp=4", idx - last); end
                    end
                    last = idx;
                end
            end
        end
        reset_edge(1'b0);
        void'(q1.pop_front()); void'(q2.pop_front());
        for (int r = 0; r < 300; r++) begin
            for (int i = 4; i >= 0; i--) begin
                send_bit(p5[i]);
                e1 = q1.pop_front(); e2 = q2.pop_front();
                checks += 2;
                if (y2 !== e2) begin failures++; $display("FAIL b2b5_y2 rep%0d got=%b exp=%b", r, y2, e2); end
                if (y2 !== (i == 0)) begin failures++; $display("FAIL b2b5_vec rep%0d got=%b exp=%b", r, y2, (i == 0)); end
            end
`ifdef SEQ_NONOVERLAP_DETCNT_EN
            if (r == 0) begin
                checks++;
                if (cnt2 !== 8'd1) begin failures++; $display("FAIL cnt2_first got=%0d exp=1", cnt2); end
            end
`endif
        end
`ifdef SEQ_NONOVERLAP_DETCNT_EN
        checks += 2;
        if (cnt2 !== 8'd255) begin failures++; $display("FAIL cnt2_sat got=%0d exp=255", cnt2); end
        if (cnt1 !== 8'(mc1)) begin failures++; $display("FAIL cnt1_b2b got=%0d exp=%0d", cnt1, mc1); end
`endif
    endtask

    task automatic test_random();
        logic e1, e2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_edge(1'($urandom_range(0, 1)));
            end else begin
                send_bit(1'($urandom_range(0, 3) != 0));
            end
            e1 = q1.pop_front(); e2 = q2.pop_front();
            checks += 2;
            if (y1 !== e1) begin failures++; $display("FAIL rand_y1 step%0d got=%b exp=%b", i, y1, e1); end
            if (y2 !== e2) begin failures++; $display("FAIL rand_y2 step%0d got=%b exp=%b", i, y2, e2); end
`ifdef SEQ_NONOVERLAP_DETCNT_EN
            checks += 2;
            if (cnt1 !== 8'(mc1)) begin failures++; $display("FAIL rand_cnt1 step%0d got=%0d exp=%0d", i, cnt1, mc1); end
            if (cnt2 !== 8'(mc2)) begin failures++; $display("FAIL rand_cnt2 step%0d got=%0d exp=%0d", i, cnt2, mc2); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        x   = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream("basic",    16'b1011011,  16'b0001000,  7, 1'b0);
        test_stream("twice",    16'b10111011, 16'b00010001, 8, 1'b0);
        test_stream("fallback", 16'b101011,   16'b000001,   6, 1'b0);
        test_reset_mid_match();
        test_stream("pat5",     16'b111011,   16'b000001,   6, 1'b1);
`ifdef SEQ_NONOVERLAP_DETCNT_EN
        checks++;
        if (cnt2 !== 8'd1) begin failures++; $display("FAIL pat5_cnt got=%0d exp=1", cnt2); end
`endif
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
